bf2_stage: RTL

BF2_STAGE -- requirements
Module: bf2_stage

---
 rtl/bf2_pkg.sv | 18 +
 rtl/bf2_if.sv | 50 +++++
 rtl/bf2_lane.sv | 91 +++++++++
 rtl/bf2_stage.sv | 94 +++++++++
 4 files changed

// File: rtl/bf2_pkg.sv
// bf2 butterfly stage: shared defaults, mode enum and counter width helper.
// Optional build macro: BF2_ROUND_EN (round-half-up when scaling).
package bf2_pkg;

  localparam int BF2_WIDTH     = 9;
  localparam int BF2_LANES     = 16;
  localparam int BF2_FRAME_LEN = 4;

  typedef enum logic {
    BF2_MODE_I  = 1'b0,
    BF2_MODE_II = 1'b1
  } bf2_mode_e;

  function automatic int bf2_cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bf2_if.sv
// bf2 butterfly stage: beat-level handshake bundle.
// Optional build macro: BF2_ROUND_EN (affects only the datapath).
interface bf2_if
  import bf2_pkg::*;
#(
  parameter int WIDTH     = BF2_WIDTH,
  parameter int LANES     = BF2_LANES,
  parameter int FRAME_LEN = BF2_FRAME_LEN
) ();

  localparam int IW = bf2_cnt_w(FRAME_LEN);

  logic                            in_valid;
  logic                            in_ready;
  logic                            mode_i;
  logic                            scale_i;
  logic [LANES-1:0][WIDTH-1:0]     din_r1;
  logic [LANES-1:0][WIDTH-1:0]     din_r2;
  logic [LANES-1:0][WIDTH-1:0]     din_q1;
  logic [LANES-1:0][WIDTH-1:0]     din_q2;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic [LANES-1:0][WIDTH:0]       dout_r_add;
  logic [LANES-1:0][WIDTH:0]       dout_r_sub;
  logic [LANES-1:0][WIDTH:0]       dout_q_add;
  logic [LANES-1:0][WIDTH:0]       dout_q_sub;
  logic [IW-1:0]                   beat_idx_o;

  modport master (
    output in_valid, mode_i, scale_i,
    output din_r1, din_r2, din_q1, din_q2,
    output out_ready,
    input  in_ready, out_valid, out_last,
    input  dout_r_add, dout_r_sub,
    input  dout_q_add, dout_q_sub,
    input  beat_idx_o
  );

  modport slave (
    input  in_valid, mode_i, scale_i,
    input  din_r1, din_r2, din_q1, din_q2,
    input  out_ready,
    output in_ready, out_valid, out_last,
    output dout_r_add, dout_r_sub,
    output dout_q_add, dout_q_sub,
    output beat_idx_o
  );

endinterface

// File: rtl/bf2_lane.sv
// bf2 single lane: S1 add/sub, S2 -j rotate and optional halving.
// Optional build macro: BF2_ROUND_EN (round-half-up instead of truncate).
module bf2_lane #(
  parameter int WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld1_i,
  input  logic                    ld2_i,
  input  logic                    rot_i,
  input  logic                    scale_i,
  input  logic signed [WIDTH-1:0] r1_i,
  input  logic signed [WIDTH-1:0] r2_i,
  input  logic signed [WIDTH-1:0] q1_i,
  input  logic signed [WIDTH-1:0] q2_i,
  output logic signed [WIDTH:0]   r_add_o,
  output logic signed [WIDTH:0]   r_sub_o,
  output logic signed [WIDTH:0]   q_add_o,
  output logic signed [WIDTH:0]   q_sub_o
);

  localparam int OW = WIDTH + 1;

  logic signed [OW-1:0] r1x, r2x, q1x, q2x;
  logic signed [OW-1:0] ra1_q, rs1_q, qa1_q, qs1_q;
  logic signed [OW-1:0] ra1_d, rs1_d, qa1_d, qs1_d;
  logic signed [OW-1:0] rs_rot, qs_rot;
  logic signed [OW-1:0] ra2_q, rs2_q, qa2_q, qs2_q;

  // One guard bit keeps x+1 exact before the shift.
  function automatic logic signed [OW-1:0] half(
    input logic signed [OW-1:0] x,
    input logic                 en
  );
    logic [OW:0] t;
    t = {x[OW-1], x};
`ifdef BF2_ROUND_EN
    t = t + {{OW{1'b0}}, 1'b1};
`else
    t = t;
`endif
    return en ? t[OW:1] : x;
  endfunction

  assign r1x = {r1_i[WIDTH-1], r1_i};
  assign r2x = {r2_i[WIDTH-1], r2_i};
  assign q1x = {q1_i[WIDTH-1], q1_i};
  assign q2x = {q2_i[WIDTH-1], q2_i};

  assign ra1_d = r1x + r2x;
  assign rs1_d = r1x - r2x;
  assign qa1_d = q1x + q2x;
  assign qs1_d = q1x - q2x;

  assign rs_rot = rot_i ? qs1_q : rs1_q;
  assign qs_rot = rot_i ? -rs1_q : qs1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra1_q <= '0;
      rs1_q <= '0;
      qa1_q <= '0;
      qs1_q <= '0;
    end else if (ld1_i) begin
      ra1_q <= ra1_d;
      rs1_q <= rs1_d;
      qa1_q <= qa1_d;
      qs1_q <= qs1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra2_q <= '0;
      rs2_q <= '0;
      qa2_q <= '0;
      qs2_q <= '0;
    end else if (ld2_i) begin
      ra2_q <= half(ra1_q, scale_i);
      rs2_q <= half(rs_rot, scale_i);
      qa2_q <= half(qa1_q, scale_i);
      qs2_q <= half(qs_rot, scale_i);
    end
  end

  assign r_add_o = ra2_q;
  assign r_sub_o = rs2_q;
  assign q_add_o = qa2_q;
  assign q_sub_o = qs2_q;

endmodule

// File: rtl/bf2_stage.sv
// bf2 radix-2^2 butterfly stage: handshake, beat counter, lane array.
// Optional build macro: BF2_ROUND_EN (rounded scaling in bf2_lane).
module bf2_stage
  import bf2_pkg::*;
#(
  parameter int WIDTH     = BF2_WIDTH,
  parameter int LANES     = BF2_LANES,
  parameter int FRAME_LEN = BF2_FRAME_LEN
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  mode_i,
  input  logic                                  scale_i,
  input  logic signed [LANES-1:0][WIDTH-1:0]    din_r1,
  input  logic signed [LANES-1:0][WIDTH-1:0]    din_r2,
  input  logic signed [LANES-1:0][WIDTH-1:0]    din_q1,
  input  logic signed [LANES-1:0][WIDTH-1:0]    din_q2,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic signed [LANES-1:0][WIDTH:0]      dout_r_add,
  output logic signed [LANES-1:0][WIDTH:0]      dout_r_sub,
  output logic signed [LANES-1:0][WIDTH:0]      dout_q_add,
  output logic signed [LANES-1:0][WIDTH:0]      dout_q_sub,
  output logic [bf2_cnt_w(FRAME_LEN)-1:0]       beat_idx_o
);

  localparam int IW = bf2_cnt_w(FRAME_LEN);
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] HALF = IW'(FRAME_LEN / 2);

  logic          v1_q, v2_q;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx1_q, idx2_q;
  bf2_mode_e     mode1_q;
  logic          scale1_q;
  logic          adv1, adv2, in_fire, ld2, rot;

  assign adv2    = out_ready | ~v2_q;
  assign adv1    = ~v1_q | adv2;
  assign in_fire = in_valid & adv1;
  assign ld2     = adv2 & v1_q;
  assign rot     = (mode1_q == BF2_MODE_II) && (idx1_q >= HALF);
  assign cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      cnt_q    <= '0;
      idx1_q   <= '0;
      idx2_q   <= '0;
      mode1_q  <= BF2_MODE_I;
      scale1_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv2) v2_q <= v1_q;
      if (in_fire) begin
        cnt_q    <= cnt_d;
        idx1_q   <= cnt_q;
        mode1_q  <= mode_i ? BF2_MODE_II : BF2_MODE_I;
        scale1_q <= scale_i;
      end
      if (ld2) idx2_q <= idx1_q;
    end
  end

  assign in_ready   = adv1;
  assign out_valid  = v2_q;
  assign beat_idx_o = idx2_q;
  assign out_last   = (idx2_q == LAST);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bf2_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld1_i   (in_fire),
      .ld2_i   (ld2),
      .rot_i   (rot),
      .scale_i (scale1_q),
      .r1_i    (din_r1[g]),
      .r2_i    (din_r2[g]),
      .q1_i    (din_q1[g]),
      .q2_i    (din_q2[g]),
      .r_add_o (dout_r_add[g]),
      .r_sub_o (dout_r_sub[g]),
      .q_add_o (dout_q_add[g]),
      .q_sub_o (dout_q_sub[g])
    );
  end

endmodule
